// File: rtl/ddr_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// ddr_port_arbiter_if
// Handshake and bus signals between the DDR port arbiter, its two requesters
// (pixel-packer writer, VGA prefetch reader) and the DDR controller user port.
//
// Modports:
//   master : the arbiter side (drives acks, read return data, controller cmds)
//   slave  : the environment side (requesters and controller)
//
// Signal groups:
//   writer     : wr_req, wr_addr, wr_data / wr_ack
//   reader     : rd_req, rd_urgent, rd_addr / rd_ack, rd_data, rd_valid
//   controller : ctrl_wr_en, ctrl_wr_addr, ctrl_wr_data, ctrl_rd_en,
//                ctrl_rd_addr / ctrl_wr_busy, ctrl_rd_busy, ctrl_rd_data,
//                ctrl_rd_data_valid
// ---------------------------------------------------------------------------
interface ddr_port_arbiter_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 128
);
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;

    logic              rd_req;
    logic              rd_urgent;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    logic              ctrl_wr_en;
    logic [ADDR_W-1:0] ctrl_wr_addr;
    logic [DATA_W-1:0] ctrl_wr_data;
    logic              ctrl_wr_busy;
    logic              ctrl_rd_en;
    logic [ADDR_W-1:0] ctrl_rd_addr;
    logic              ctrl_rd_busy;
    logic [DATA_W-1:0] ctrl_rd_data;
    logic              ctrl_rd_data_valid;

    modport master (
        input  wr_req, wr_addr, wr_data,
        output wr_ack,
        input  rd_req, rd_urgent, rd_addr,
        output rd_ack, rd_data, rd_valid,
        output ctrl_wr_en, ctrl_wr_addr, ctrl_wr_data,
        input  ctrl_wr_busy,
        output ctrl_rd_en, ctrl_rd_addr,
        input  ctrl_rd_busy, ctrl_rd_data, ctrl_rd_data_valid
    );

    modport slave (
        output wr_req, wr_addr, wr_data,
        input  wr_ack,
        output rd_req, rd_urgent, rd_addr,
        input  rd_ack, rd_data, rd_valid,
        input  ctrl_wr_en, ctrl_wr_addr, ctrl_wr_data,
        output ctrl_wr_busy,
        input  ctrl_rd_en, ctrl_rd_addr,
        output ctrl_rd_busy, ctrl_rd_data, ctrl_rd_data_valid
    );
endinterface

// File: rtl/ddr_port_arbiter.sv
// ---------------------------------------------------------------------------
// ddr_port_arbiter
// Shares the single user port of the DDR controller between the pixel-packer
// writer and the VGA prefetch reader. One command is outstanding at a time.
// Urgent reads beat writes; otherwise writes stream for up to WR_BURST_MAX
// grants before one waiting read is let through. Reads that never return
// data are aborted after RD_TIMEOUT cycles and flagged sticky.
//
// Ports:
//   clk            ui_clk, rising edge
//   rst            asynchronous, active-high
//   bus            ddr_port_arbiter_if.master (requesters + controller)
//   rd_timeout_err sticky read-timeout flag, cleared only by rst
//   arb_idle       FSM is in IDLE
//   stat_wr_cnt    writes issued   (only with DDR_ARB_STATS_EN, else 0)
//   stat_rd_cnt    reads completed (only with DDR_ARB_STATS_EN, else 0)
//
// Build option: define DDR_ARB_STATS_EN to get saturating 32-bit statistics
// counters; without it the stat ports are tied to zero.
//
// state   | meaning
// IDLE    | no command outstanding, arbitrating each cycle
// WR_WAIT | write issued; first cycle is a guard, then wait for !ctrl_wr_busy
// RD_WAIT | read issued; wait for ctrl_rd_data_valid or timeout
// ---------------------------------------------------------------------------
module ddr_port_arbiter #(
    parameter int ADDR_W       = 24,
    parameter int DATA_W       = 128,
    parameter int WR_BURST_MAX = 8,
    parameter int RD_TIMEOUT   = 1023
) (
    input  logic                    clk,
    input  logic                    rst,
    ddr_port_arbiter_if.master      bus,
    output logic                    rd_timeout_err,
    output logic                    arb_idle,
    output logic [31:0]             stat_wr_cnt,
    output logic [31:0]             stat_rd_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_WAIT = 2'd1,
        RD_WAIT = 2'd2
    } state_t;

    localparam int STREAK_W = $clog2(WR_BURST_MAX + 1);
    localparam int TMO_W    = $clog2(RD_TIMEOUT + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(WR_BURST_MAX);
    // Down-counter reaches zero on the RD_TIMEOUT-th RD_WAIT cycle.
    localparam logic [TMO_W-1:0]    TMO_LOAD   = TMO_W'(RD_TIMEOUT - 1);

    state_t              state;
    logic [STREAK_W-1:0] streak;
    logic [TMO_W-1:0]    tmo_cnt;

    logic rd_ok;
    logic wr_ok;
    logic grant_rd;
    logic grant_wr;

    // A busy-blocked requester simply drops out of arbitration, so the other
    // one can still be served.
    always_comb begin
        rd_ok    = bus.rd_req & ~bus.ctrl_rd_busy;
        wr_ok    = bus.wr_req & ~bus.ctrl_wr_busy;
        grant_rd = rd_ok & (bus.rd_urgent | (streak == STREAK_MAX) | ~wr_ok);
        grant_wr = wr_ok & ~grant_rd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            streak           <= '0;
            tmo_cnt          <= '0;
            arb_idle         <= 1'b1;
            rd_timeout_err   <= 1'b0;
            bus.wr_ack       <= 1'b0;
            bus.rd_ack       <= 1'b0;
            bus.rd_valid     <= 1'b0;
            bus.rd_data      <= '0;
            bus.ctrl_wr_en   <= 1'b0;
            bus.ctrl_wr_addr <= '0;
            bus.ctrl_wr_data <= '0;
            bus.ctrl_rd_en   <= 1'b0;
            bus.ctrl_rd_addr <= '0;
        end else begin
            bus.wr_ack     <= 1'b0;
            bus.rd_ack     <= 1'b0;
            bus.rd_valid   <= 1'b0;
            bus.ctrl_wr_en <= 1'b0;
            bus.ctrl_rd_en <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant_rd) begin
                        bus.ctrl_rd_en   <= 1'b1;
                        bus.rd_ack       <= 1'b1;
                        bus.ctrl_rd_addr <= bus.rd_addr;
                        streak           <= '0;
                        tmo_cnt          <= TMO_LOAD;
                        state            <= RD_WAIT;
                        arb_idle         <= 1'b0;
                    end else if (grant_wr) begin
                        bus.ctrl_wr_en   <= 1'b1;
                        bus.wr_ack       <= 1'b1;
                        bus.ctrl_wr_addr <= bus.wr_addr;
                        bus.ctrl_wr_data <= bus.wr_data;
                        if (streak != STREAK_MAX) begin
                            streak <= streak + 1'b1;
                        end
                        state            <= WR_WAIT;
                        arb_idle         <= 1'b0;
                    end
                end

                WR_WAIT: begin
                    // ctrl_wr_en is high only in the issue cycle, which doubles
                    // as the guard cycle while the controller raises busy.
                    if (!bus.ctrl_wr_en && !bus.ctrl_wr_busy) begin
                        state    <= IDLE;
                        arb_idle <= 1'b1;
                    end
                end

                RD_WAIT: begin
                    if (bus.ctrl_rd_data_valid) begin
                        bus.rd_data  <= bus.ctrl_rd_data;
                        bus.rd_valid <= 1'b1;
                        state        <= IDLE;
                        arb_idle     <= 1'b1;
                    end else if (tmo_cnt == '0) begin
                        rd_timeout_err <= 1'b1;
                        state          <= IDLE;
                        arb_idle       <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                    end
                end

                default: begin
                    state    <= IDLE;
                    arb_idle <= 1'b1;
                end
            endcase
        end
    end

`ifdef DDR_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_wr_cnt <= '0;
            stat_rd_cnt <= '0;
        end else begin
            if (bus.ctrl_wr_en && (stat_wr_cnt != 32'hFFFF_FFFF)) begin
                stat_wr_cnt <= stat_wr_cnt + 32'd1;
            end
            if (bus.rd_valid && (stat_rd_cnt != 32'hFFFF_FFFF)) begin
                stat_rd_cnt <= stat_rd_cnt + 32'd1;
            end
        end
    end
`else
    assign stat_wr_cnt = 32'd0;
    assign stat_rd_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ddr_port_arbiter
// Directed bench for ddr_port_arbiter: single write/read, write streaming vs
// non-urgent read, urgent read priority, busy blocking, read timeout, reset
// in RD_WAIT and the statistics ports.
// ---------------------------------------------------------------------------
module tb_ddr_port_arbiter;

    localparam int ADDR_W     = 24;
    localparam int DATA_W     = 128;
    localparam int RD_TIMEOUT = 1023;
    localparam byte ID_W      = 8'h57;
    localparam byte ID_R      = 8'h52;

    logic        clk;
    logic        rst;
    logic        rd_timeout_err;
    logic        arb_idle;
    logic [31:0] stat_wr_cnt;
    logic [31:0] stat_rd_cnt;

    ddr_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ddr_port_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .WR_BURST_MAX(8),
        .RD_TIMEOUT  (RD_TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .rd_timeout_err(rd_timeout_err),
        .arb_idle      (arb_idle),
        .stat_wr_cnt   (stat_wr_cnt),
        .stat_rd_cnt   (stat_rd_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Controller read responder: returns data rsp_delay cycles after ctrl_rd_en.
    logic         rsp_valid = 1'b0;
    logic         inj_valid = 1'b0;
    bit           rsp_en    = 1'b1;
    int           rsp_delay = 12;
    logic [127:0] rsp_data  = '0;
    int           rsp_cnt   = 0;

    assign bus.ctrl_rd_data_valid = rsp_valid | inj_valid;

    always @(negedge clk) begin
        rsp_valid = 1'b0;
        if (bus.ctrl_rd_en === 1'b1) begin
            if (rsp_en) rsp_cnt = rsp_delay;
        end else if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
                rsp_valid        = 1'b1;
                bus.ctrl_rd_data = rsp_data;
            end
        end
    end

    // Monitor: grant order log and event counters.
    byte q[$];
    int  cyc          = 0;
    int  last_wr_cyc  = 0;
    int  last_rdv_cyc = 0;
    int  n_rdv        = 0;
    int  n_wren       = 0;

    always @(negedge clk) begin
        if (!rst) begin
            cyc++;
            if (bus.wr_ack === 1'b1) begin
                q.push_back(ID_W);
                last_wr_cyc = cyc;
            end
            if (bus.rd_ack === 1'b1) q.push_back(ID_R);
            if (bus.ctrl_wr_en === 1'b1) n_wren++;
            if (bus.rd_valid === 1'b1) begin
                n_rdv++;
                last_rdv_cyc = cyc;
            end
        end
    end

    task automatic wait_wr_ack(input string tag, input int lim);
        int k = 0;
        while (bus.wr_ack !== 1'b1 && k < lim) begin
            tick();
            k++;
        end
        check(tag, bus.wr_ack, 1'b1);
    endtask

    task automatic wait_rd_ack(input string tag, input int lim);
        int k = 0;
        while (bus.rd_ack !== 1'b1 && k < lim) begin
            tick();
            k++;
        end
        check(tag, bus.rd_ack, 1'b1);
    endtask

    task automatic wait_idle(input string tag, input int lim);
        int k = 0;
        while (arb_idle !== 1'b1 && k < lim) begin
            tick();
            k++;
        end
        check(tag, arb_idle, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int nw;
        int rdv_before;

        rst                  = 1'b0;
        bus.wr_req           = 1'b0;
        bus.wr_addr          = '0;
        bus.wr_data          = '0;
        bus.rd_req           = 1'b0;
        bus.rd_urgent        = 1'b0;
        bus.rd_addr          = '0;
        bus.ctrl_wr_busy     = 1'b0;
        bus.ctrl_rd_busy     = 1'b0;
        bus.ctrl_rd_data     = '0;
        #1 rst = 1'b1;
        #2;

        // Reset state
        check("rst_arb_idle", arb_idle, 1'b1);
        check("rst_wr_ack", bus.wr_ack, 1'b0);
        check("rst_ctrl_wr_en", bus.ctrl_wr_en, 1'b0);
        check("rst_ctrl_rd_en", bus.ctrl_rd_en, 1'b0);
        check("rst_rd_valid", bus.rd_valid, 1'b0);
        check("rst_timeout_err", rd_timeout_err, 1'b0);
        check("rst_stat_wr", stat_wr_cnt, 32'd0);
        tick(2);
        rst = 1'b0;
        tick();

        // T1: single write
        bus.wr_req  = 1'b1;
        bus.wr_addr = 24'h000010;
        bus.wr_data = {16{8'hA5}};
        tick();
        check("t1_wr_ack", bus.wr_ack, 1'b1);
        check("t1_ctrl_wr_en", bus.ctrl_wr_en, 1'b1);
        check("t1_ctrl_wr_addr", bus.ctrl_wr_addr, 24'h000010);
        check("t1_ctrl_wr_data", bus.ctrl_wr_data, {16{8'hA5}});
        bus.wr_req  = 1'b0;
        bus.wr_addr = 24'h0;
        tick();
        check("t1_wr_ack_pulse", bus.wr_ack, 1'b0);
        check("t1_wr_en_pulse", bus.ctrl_wr_en, 1'b0);
        check("t1_busy_state", arb_idle, 1'b0);
        tick();
        check("t1_back_idle", arb_idle, 1'b1);
        check("t1_ctrl_addr_held", bus.ctrl_wr_addr, 24'h000010);

        // T2: single read with 12-cycle controller latency
        rsp_delay   = 12;
        rsp_data    = 128'h1234;
        bus.rd_req  = 1'b1;
        bus.rd_addr = 24'h000020;
        tick();
        check("t2_rd_ack", bus.rd_ack, 1'b1);
        check("t2_ctrl_rd_en", bus.ctrl_rd_en, 1'b1);
        check("t2_ctrl_rd_addr", bus.ctrl_rd_addr, 24'h000020);
        bus.rd_req = 1'b0;
        k = 0;
        while (bus.ctrl_rd_data_valid !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        check("t2_ctrl_valid_seen", bus.ctrl_rd_data_valid, 1'b1);
        check("t2_rd_valid_not_early", bus.rd_valid, 1'b0);
        tick();
        check("t2_rd_valid", bus.rd_valid, 1'b1);
        check("t2_rd_data", bus.rd_data, 128'h1234);
        check("t2_idle_after_rd", arb_idle, 1'b1);
        tick();
        check("t2_rd_valid_pulse", bus.rd_valid, 1'b0);

        // T3: write streaming vs. non-urgent read (streak is 0 after T2)
        q.delete();
        rsp_delay   = 3;
        rsp_data    = 128'h55;
        bus.wr_req  = 1'b1;
        bus.wr_addr = 24'h000100;
        bus.rd_req  = 1'b1;
        bus.rd_addr = 24'h000200;
        k = 0;
        while (q.size() < 10 && k < 300) begin
            tick();
            k++;
        end
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        check("t3_grants", q.size(), 10);
        nw = 0;
        for (int i = 0; i < 8; i++) if (q[i] == ID_W) nw++;
        check("t3_write_streak", nw, 8);
        check("t3_read_after_streak", q[8], ID_R);
        check("t3_writes_resume", q[9], ID_W);
        wait_idle("t3_idle", 40);

        // T4: urgent read beats a simultaneous write
        q.delete();
        rsp_delay     = 5;
        rsp_data      = 128'hBEEF;
        bus.wr_req    = 1'b1;
        bus.rd_req    = 1'b1;
        bus.rd_urgent = 1'b1;
        wait_rd_ack("t4_rd_ack", 20);
        bus.rd_req    = 1'b0;
        bus.rd_urgent = 1'b0;
        wait_wr_ack("t4_wr_ack", 60);
        bus.wr_req = 1'b0;
        check("t4_first_read", q[0], ID_R);
        check("t4_then_write", q[1], ID_W);
        check("t4_wr_after_rd_done", last_wr_cyc > last_rdv_cyc, 1'b1);
        check("t4_rd_data", bus.rd_data, 128'hBEEF);
        wait_idle("t4_idle", 20);

        // T7a: write blocked by ctrl_wr_busy does not block the read
        q.delete();
        bus.ctrl_wr_busy = 1'b1;
        bus.wr_req       = 1'b1;
        bus.rd_req       = 1'b1;
        wait_rd_ack("t7_rd_ack", 20);
        bus.rd_req = 1'b0;
        check("t7_read_first", q[0], ID_R);
        wait_idle("t7_idle_rd", 40);
        tick(3);
        check("t7_no_write_while_busy", q.size(), 1);
        bus.ctrl_wr_busy = 1'b0;
        wait_wr_ack("t7_wr_ack", 10);
        bus.wr_req       = 1'b0;
        bus.ctrl_wr_busy = 1'b1;
        tick(5);
        check("t7_wr_wait_holds", arb_idle, 1'b0);
        bus.ctrl_wr_busy = 1'b0;
        tick();
        check("t7_wr_wait_release", arb_idle, 1'b1);

        // T7b: read blocked by ctrl_rd_busy does not block the write
        q.delete();
        bus.ctrl_rd_busy = 1'b1;
        bus.rd_req       = 1'b1;
        bus.rd_urgent    = 1'b1;
        bus.wr_req       = 1'b1;
        wait_wr_ack("t7b_wr_ack", 10);
        bus.wr_req = 1'b0;
        check("t7b_write_first", q[0], ID_W);
        tick(3);
        bus.ctrl_rd_busy = 1'b0;
        wait_rd_ack("t7b_rd_ack", 10);
        bus.rd_req    = 1'b0;
        bus.rd_urgent = 1'b0;
        wait_idle("t7b_idle", 40);

        // Statistics ports
`ifdef DDR_ARB_STATS_EN
        check("stat_wr_cnt", stat_wr_cnt, n_wren);
        check("stat_rd_cnt", stat_rd_cnt, n_rdv);
`else
        check("stat_wr_cnt_off", stat_wr_cnt, 32'd0);
        check("stat_rd_cnt_off", stat_rd_cnt, 32'd0);
`endif

        // T5: read that never returns data
        rsp_en     = 1'b0;
        bus.rd_req = 1'b1;
        wait_rd_ack("t5_rd_ack", 10);
        bus.rd_req = 1'b0;
        rdv_before = n_rdv;
        tick(RD_TIMEOUT - 10);
        check("t5_no_err_early", rd_timeout_err, 1'b0);
        check("t5_still_waiting", arb_idle, 1'b0);
        tick(20);
        check("t5_timeout_err", rd_timeout_err, 1'b1);
        check("t5_idle_after_timeout", arb_idle, 1'b1);
        inj_valid = 1'b1;
        tick();
        inj_valid = 1'b0;
        tick(2);
        check("t5_late_valid_ignored", n_rdv - rdv_before, 0);
        check("t5_err_sticky", rd_timeout_err, 1'b1);

        // T6: reset asserted in RD_WAIT
        rsp_en     = 1'b1;
        rsp_delay  = 10;
        bus.rd_req = 1'b1;
        wait_rd_ack("t6_rd_ack", 10);
        bus.rd_req = 1'b0;
        tick(3);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_idle", arb_idle, 1'b1);
        check("t6_rst_err_clear", rd_timeout_err, 1'b0);
        check("t6_rst_rd_valid", bus.rd_valid, 1'b0);
        check("t6_rst_ctrl_rd_addr", bus.ctrl_rd_addr, 24'h0);
        check("t6_rst_stat_wr", stat_wr_cnt, 32'd0);
        check("t6_rst_stat_rd", stat_rd_cnt, 32'd0);
        tick();
        rst        = 1'b0;
        rdv_before = n_rdv;
        tick(20);
        check("t6_valid_after_rst_ignored", n_rdv - rdv_before, 0);
        check("t6_idle_after_rst", arb_idle, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
